uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync2.sv | 33 +++
 rtl/uart_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_rx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and framing constants for the rx path, tx path and baud generator setup.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous inputs; 2-cycle latency, no backpressure.
`timescale 1ns/1ps
module uart_sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic [WIDTH-1:0] i_D,
    output logic [WIDTH-1:0] o_Q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = i_D;
        sync_d = meta_q;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_Q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver on an oversampling tick; strobes one cycle after the stop-sample tick.
// No backpressure: o_Data/o_Valid must be taken when presented, framing errors pulse o_FrameErr.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Tick,
    input  logic                 i_Rx,
    output logic [DATA_BITS-1:0] o_Data,
    output logic                 o_Valid,
    output logic                 o_FrameErr,
    output logic                 o_Busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic rx_s;

    rx_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   busy_q, busy_d;

    uart_sync2 #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_D   (i_Rx),
        .o_Q   (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            START: begin
                if (i_Tick) begin
                    if (cnt_q == CNT_MID) begin
                        // A high line at mid start bit is a glitch, not a frame.
                        if (!rx_s) begin
                            state_d   = DATA;
                            cnt_d     = '0;
                            bit_idx_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            DATA: begin
                if (i_Tick) begin
                    if (cnt_q == CNT_LAST) begin
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        cnt_d   = '0;
                        if (bit_idx_q == IDX_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + IDX_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            STOP: begin
                if (i_Tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_HIGH;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            // Holding here through a break keeps it from decoding as 0x00 frames.
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign o_Data     = data_q;
    assign o_Valid    = valid_q;
    assign o_FrameErr = ferr_q;
    assign o_Busy     = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick every 4 clocks, 16 ticks per bit, scoreboard of expected strobes.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT_CLKS = 64;

    logic       i_Clk;
    logic       i_Rst;
    logic       i_Tick;
    logic       i_Rx;
    logic [7:0] o_Data;
    logic       o_Valid;
    logic       o_FrameErr;
    logic       o_Busy;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        int         fall;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    uart_rx #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Tick     (i_Tick),
        .i_Rx       (i_Rx),
        .o_Data     (o_Data),
        .o_Valid    (o_Valid),
        .o_FrameErr (o_FrameErr),
        .o_Busy     (o_Busy)
    );

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    initial begin
        forever begin
            @(posedge i_Clk);
            cyc++;
        end
    end

    initial begin
        i_Tick = 1'b0;
        forever begin
            @(negedge i_Clk);
            i_Tick = ((cyc % 4) == 3);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Strobe monitor: every o_Valid/o_FrameErr pulse must match the oldest expected frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_Clk);
            if (!i_Rst && (o_Valid || o_FrameErr)) begin
                chk("strobe_expected", 32'(sb.size() != 0), 32'd1);
                chk("valid_ferr_excl", 32'(o_Valid && o_FrameErr), 32'd0);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("strobe_kind", 32'(o_FrameErr), 32'(e.ferr));
                    if (!e.ferr) begin
                        chk("strobe_data", 32'(o_Data), 32'(e.data));
                    end
                    chk("strobe_time",
                        32'((cyc >= e.fall + 606) && (cyc <= e.fall + 613)), 32'd1);
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        i_Rx = b;
        repeat (BIT_CLKS) @(negedge i_Clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        exp_t e;
        e.ferr = !stop_bit;
        e.data = data;
        e.fall = cyc;
        sb.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(data[i]);
        end
        send_bit(stop_bit);
    endtask

    initial begin
        int fall;
        i_Rst = 1'b0;
        i_Rx  = 1'b1;
        #2 i_Rst = 1'b1;
        repeat (3) @(negedge i_Clk);
        chk("rst_data",  32'(o_Data),     32'd0);
        chk("rst_valid", 32'(o_Valid),    32'd0);
        chk("rst_ferr",  32'(o_FrameErr), 32'd0);
        chk("rst_busy",  32'(o_Busy),     32'd0);
        i_Rst = 1'b0;

        repeat (2000) @(negedge i_Clk);
        chk("idle_busy", 32'(o_Busy), 32'd0);
        chk("idle_data", 32'(o_Data), 32'd0);

        send_frame(8'hA5, 1'b1);
        chk("a5_pending", 32'(sb.size()), 32'd0);
        chk("a5_data",    32'(o_Data),    32'hA5);
        send_bit(1'b1);

        fall = cyc;
        i_Rx = 1'b0;
        repeat (10) @(negedge i_Clk);
        chk("glitch_busy_hi", 32'(o_Busy), 32'd1);
        repeat (10) @(negedge i_Clk);
        i_Rx = 1'b1;
        repeat (fall + 60 - cyc) @(negedge i_Clk);
        chk("glitch_busy_lo", 32'(o_Busy), 32'd0);
        chk("glitch_data",    32'(o_Data), 32'hA5);
        send_bit(1'b1);

        send_frame(8'h3C, 1'b0);
        repeat (2 * BIT_CLKS) @(negedge i_Clk);
        chk("ferr_pending",   32'(sb.size()), 32'd0);
        chk("ferr_data_hold", 32'(o_Data),    32'hA5);
        chk("ferr_wait_busy", 32'(o_Busy),    32'd1);
        i_Rx = 1'b1;
        repeat (10) @(negedge i_Clk);
        chk("ferr_recover_busy", 32'(o_Busy), 32'd0);
        send_bit(1'b1);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        chk("b2b_pending", 32'(sb.size()), 32'd0);
        chk("b2b_data",    32'(o_Data),    32'h55);
        send_bit(1'b1);

        // 0x81 cut short by reset during bit 4 (a 0 on the line).
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) begin
            send_bit(1'(8'h81 >> i));
        end
        i_Rx = 1'b0;
        repeat (30) @(negedge i_Clk);
        chk("mid_frame_busy", 32'(o_Busy), 32'd1);
        i_Rst = 1'b1;
        repeat (5) @(negedge i_Clk);
        chk("rst_mid_data", 32'(o_Data), 32'd0);
        chk("rst_mid_busy", 32'(o_Busy), 32'd0);
        i_Rst = 1'b0;
        i_Rx  = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge i_Clk);
        chk("post_rst_busy", 32'(o_Busy), 32'd0);
        chk("post_rst_data", 32'(o_Data), 32'd0);

        send_frame(8'h42, 1'b1);
        chk("42_pending", 32'(sb.size()), 32'd0);
        chk("42_data",    32'(o_Data),    32'h42);
        send_bit(1'b1);
        chk("final_busy", 32'(o_Busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
